bolme_param: RTL and testbench
==============================

BOLME_PARAM -- requirements
Module: bolme_param

Interface
REQ-001 Parameter GENISLIK, 32, total operand and result width in bits (>= 8).
REQ-002 Parameter KESIR, 16, fraction bits of the fixed-point format (1 .. GENISLIK-1).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 basla  input  1  start request; accepted only when hazir=1.
REQ-007 bolunen  input  GENISLIK  dividend, Q(GENISLIK-KESIR).KESIR.
REQ-008 bolen  input  GENISLIK  divisor, same format.
REQ-009 sonuc  output  GENISLIK  quotient, same format; held until the next acceptance.
REQ-010 hazir  output  1  idle, able to accept basla.
REQ-011 gecerli  output  1  one-cycle pulse marking a new sonuc.
REQ-012 tasma  output  1  quotient overflow; valid with gecerli, held with sonuc.
REQ-013 sifira_bolme  output  1  divide-by-zero; valid with gecerli, held with sonuc.

Function
REQ-014 States: BOS (idle), HESAP (iterate), BITTI (publish); the reset state is BOS.
REQ-015 BOS: hazir=1; on basla=1, latch bolunen/bolen in the same edge, clear tasma/sifira_bolme, and go to HESAP; otherwise stay in BOS.
REQ-016 basla while hazir=0 is ignored; operand changes after acceptance have no effect.
REQ-017 Exact quotient Q = floor(bolunen * 2^KESIR / bolen), computed by restoring long division over a (GENISLIK+KESIR)-bit partial dividend, one quotient bit per cycle, MSB first.
REQ-018 HESAP lasts exactly GENISLIK+KESIR cycles, then BITTI lasts 1 cycle with gecerli=1, then BOS.
REQ-019 Latency from the accepting edge to gecerli high = GENISLIK+KESIR+1 cycles (49 at defaults); throughput is one division per GENISLIK+KESIR+2 cycles.
REQ-020 If Q >= 2^GENISLIK: tasma=1 and sonuc saturates to all ones.
REQ-021 If Q < 2^GENISLIK: tasma=0 and sonuc = Q[GENISLIK-1:0].
REQ-022 bolen=0 at acceptance: skip HESAP and go directly to BITTI, with sonuc=0, sifira_bolme=1, tasma=0; gecerli rises 1 cycle after acceptance.
REQ-023 bolunen=0 with nonzero bolen takes the normal path and yields sonuc=0, tasma=0.
REQ-024 basla in the BITTI cycle is ignored; it is accepted in the following BOS cycle.

Reset
REQ-025 rst_n=0 forces, without waiting for a clock: state=BOS, hazir=1, gecerli=0, tasma=0, sifira_bolme=0, sonuc=0, internal registers cleared.
REQ-026 Reset during HESAP or BITTI aborts the operation with no gecerli pulse; the first edge after release may accept basla.

Configuration
REQ-027 Macro BOLME_ISARETLI_EN selects the operand format.
REQ-028 With BOLME_ISARETLI_EN: operands and sonuc are two's complement; magnitudes are divided as in REQ-017, and the sign is the XOR of the operand signs, applied after truncation toward zero.
REQ-029 Signed overflow saturates to 0x7FF..F for positive results and 0x800..0 for negative results, with tasma=1.
REQ-030 Without BOLME_ISARETLI_EN: operands are unsigned, there is no sign logic, and latency is the same as in signed mode.

Verification (GENISLIK=32, KESIR=16)
REQ-031 bolunen=0x00030000, bolen=0x00020000, basla -> sonuc=0x00018000, tasma=0, gecerli exactly 49 cycles after acceptance.
REQ-032 bolunen=0x00010000, bolen=0x00030000 -> sonuc=0x00005555 (truncated), tasma=0.
REQ-033 bolunen=0x00050000, bolen=0 -> sonuc=0, sifira_bolme=1, gecerli 1 cycle after acceptance, hazir=1 the next cycle.
REQ-034 Unsigned build: bolunen=0x7FFF0000, bolen=0x00000001 -> tasma=1, sonuc=0xFFFFFFFF.
REQ-035 Signed build: bolunen=0xFFFD0000, bolen=0x00020000 -> sonuc=0xFFFE8000, tasma=0.
REQ-036 Reset pulse at cycle 20 of HESAP -> no gecerli, all outputs at reset values; an immediate new division still meets REQ-031.

Source files
------------

// File: rtl/bolme_param_if.sv
// bolme_param_if: start/operand/result bundle for the fixed-point divider.
//   master (requester): drives basla, bolunen, bolen; observes results.
//   slave  (divider)  : drives sonuc, hazir, gecerli, tasma, sifira_bolme.
interface bolme_param_if #(
  parameter int unsigned GENISLIK = 32
);
  logic                basla;
  logic [GENISLIK-1:0] bolunen;
  logic [GENISLIK-1:0] bolen;
  logic [GENISLIK-1:0] sonuc;
  logic                hazir;
  logic                gecerli;
  logic                tasma;
  logic                sifira_bolme;

  modport master (
    output basla, bolunen, bolen,
    input  sonuc, hazir, gecerli, tasma, sifira_bolme
  );

  modport slave (
    input  basla, bolunen, bolen,
    output sonuc, hazir, gecerli, tasma, sifira_bolme
  );
endinterface

// File: rtl/bolme_param.sv
// bolme_param: sequential fixed-point divider, Q = floor(bolunen * 2^KESIR / bolen),
// restoring long division, one quotient bit per clock, MSB first.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   bus     - bolme_param_if.slave: basla/bolunen/bolen in; sonuc/hazir/gecerli/
//             tasma/sifira_bolme out (all registered)
// Build option: define BOLME_ISARETLI_EN for two's-complement operands and result;
// undefined gives the unsigned divider. Latency is identical in both builds.
module bolme_param #(
  parameter int unsigned GENISLIK = 32,
  parameter int unsigned KESIR    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  bolme_param_if.slave bus
);

  localparam int unsigned W  = GENISLIK + KESIR;
  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] SON_ADIM = CW'(W - 1);

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    HESAP = 2'd1,
    BITTI = 2'd2
  } durum_t;

  durum_t              durum;
  logic [W-1:0]        bolunen_q;   // scaled dividend, shifted out MSB first
  logic [GENISLIK-1:0] bolen_q;
  logic [GENISLIK-1:0] kalan_q;     // partial remainder, always < bolen_q
  logic [W-1:0]        bolum_q;     // quotient bits collected so far
  logic [CW-1:0]       sayac_q;

  logic [GENISLIK-1:0] sonuc_q;
  logic                hazir_q;
  logic                gecerli_q;
  logic                tasma_q;
  logic                sifira_q;

  assign bus.sonuc        = sonuc_q;
  assign bus.hazir        = hazir_q;
  assign bus.gecerli      = gecerli_q;
  assign bus.tasma        = tasma_q;
  assign bus.sifira_bolme = sifira_q;

  // Operand magnitudes taken at acceptance
  logic [GENISLIK-1:0] bolunen_mag;
  logic [GENISLIK-1:0] bolen_mag;
`ifdef BOLME_ISARETLI_EN
  logic                isaret_q;
  logic                isaret_nx;

  always_comb begin
    bolunen_mag = bus.bolunen;
    bolen_mag   = bus.bolen;
    isaret_nx   = bus.bolunen[GENISLIK-1] ^ bus.bolen[GENISLIK-1];
    if (bus.bolunen[GENISLIK-1]) bolunen_mag = ~bus.bolunen + GENISLIK'(1);
    if (bus.bolen[GENISLIK-1])   bolen_mag   = ~bus.bolen + GENISLIK'(1);
  end
`else
  always_comb begin
    bolunen_mag = bus.bolunen;
    bolen_mag   = bus.bolen;
  end
`endif

  // One restoring-division step
  logic [GENISLIK:0]   kalan_kay;
  logic [GENISLIK:0]   fark;
  logic                buyuk;
  logic [GENISLIK-1:0] kalan_nx;
  logic [W-1:0]        bolum_nx;

  always_comb begin
    kalan_kay = {kalan_q, bolunen_q[W-1]};
    fark      = kalan_kay - {1'b0, bolen_q};
    buyuk     = (kalan_kay >= {1'b0, bolen_q});
    kalan_nx  = buyuk ? fark[GENISLIK-1:0] : kalan_kay[GENISLIK-1:0];
    bolum_nx  = {bolum_q[W-2:0], buyuk};
  end

  // Final result with saturation, evaluated on the last step's quotient
  logic                ust_sifir;
  logic                tasma_nx;
  logic [GENISLIK-1:0] sonuc_nx;

  always_comb begin
    ust_sifir = (bolum_nx[W-1:GENISLIK] == '0);
`ifdef BOLME_ISARETLI_EN
    if (isaret_q) begin
      // magnitude 2^(GENISLIK-1) is still representable as the most negative value
      tasma_nx = !ust_sifir || (bolum_nx[GENISLIK-1] && (bolum_nx[GENISLIK-2:0] != '0));
      sonuc_nx = tasma_nx ? {1'b1, {(GENISLIK-1){1'b0}}}
                          : (~bolum_nx[GENISLIK-1:0] + GENISLIK'(1));
    end else begin
      tasma_nx = !ust_sifir || bolum_nx[GENISLIK-1];
      sonuc_nx = tasma_nx ? {1'b0, {(GENISLIK-1){1'b1}}} : bolum_nx[GENISLIK-1:0];
    end
`else
    tasma_nx = !ust_sifir;
    sonuc_nx = tasma_nx ? {GENISLIK{1'b1}} : bolum_nx[GENISLIK-1:0];
`endif
  end

  // Control FSM and all registered state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum     <= BOS;
      bolunen_q <= '0;
      bolen_q   <= '0;
      kalan_q   <= '0;
      bolum_q   <= '0;
      sayac_q   <= '0;
      sonuc_q   <= '0;
      hazir_q   <= 1'b1;
      gecerli_q <= 1'b0;
      tasma_q   <= 1'b0;
      sifira_q  <= 1'b0;
`ifdef BOLME_ISARETLI_EN
      isaret_q  <= 1'b0;
`endif
    end else begin
      gecerli_q <= 1'b0;
      case (durum)
        BOS: begin
          if (bus.basla) begin
            bolunen_q <= {bolunen_mag, {KESIR{1'b0}}};
            bolen_q   <= bolen_mag;
            kalan_q   <= '0;
            bolum_q   <= '0;
            sayac_q   <= '0;
            tasma_q   <= 1'b0;
            sifira_q  <= 1'b0;
            hazir_q   <= 1'b0;
`ifdef BOLME_ISARETLI_EN
            isaret_q  <= isaret_nx;
`endif
            if (bus.bolen == '0) begin
              // divide-by-zero publishes immediately without iterating
              durum     <= BITTI;
              sonuc_q   <= '0;
              sifira_q  <= 1'b1;
              gecerli_q <= 1'b1;
            end else begin
              durum <= HESAP;
            end
          end
        end
        HESAP: begin
          kalan_q   <= kalan_nx;
          bolum_q   <= bolum_nx;
          bolunen_q <= {bolunen_q[W-2:0], 1'b0};
          sayac_q   <= sayac_q + CW'(1);
          if (sayac_q == SON_ADIM) begin
            durum     <= BITTI;
            sonuc_q   <= sonuc_nx;
            tasma_q   <= tasma_nx;
            gecerli_q <= 1'b1;
          end
        end
        BITTI: begin
          durum   <= BOS;
          hazir_q <= 1'b1;
        end
        default: begin
          durum   <= BOS;
          hazir_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bolme_param.sv
// tb_bolme_param: directed bench for bolme_param (GENISLIK=32, KESIR=16) with a
// cycle-level reference model checked every cycle plus literal expectations.
// Build with the same BOLME_ISARETLI_EN setting as the RTL.
module tb_bolme_param;

  localparam int unsigned G   = 32;
  localparam int unsigned K   = 16;
  localparam int          LAT = G + K + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bolme_param_if #(.GENISLIK(G)) bus ();

  bolme_param #(.GENISLIK(G), .KESIR(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference quotient computed with plain wide arithmetic
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] s, output bit t, output bit z);
`ifdef BOLME_ISARETLI_EN
    longint sa, sb, ma, mb, q;
`else
    logic [63:0] q;
`endif
    s = '0; t = 1'b0; z = 1'b0;
    if (b == 32'd0) begin
      z = 1'b1;
      return;
    end
`ifdef BOLME_ISARETLI_EN
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    q  = (ma * 65536) / mb;
    if ((sa < 0) != (sb < 0)) q = -q;
    if (q > 64'sd2147483647) begin
      s = 32'h7FFF_FFFF; t = 1'b1;
    end else if (q < -64'sd2147483648) begin
      s = 32'h8000_0000; t = 1'b1;
    end else begin
      s = 32'(q);
    end
`else
    q = ({32'd0, a} << 16) / {32'd0, b};
    if (q > 64'h0000_0000_FFFF_FFFF) begin
      s = 32'hFFFF_FFFF; t = 1'b1;
    end else begin
      s = q[31:0];
    end
`endif
  endfunction

  // Cycle model: accept in idle, publish after the fixed latency, idle again
  bit          m_busy = 1'b0;
  int          m_cnt  = 0;
  int          m_lat  = 0;
  logic [31:0] e_s = '0, h_s = '0;
  bit          e_t = 1'b0, e_z = 1'b0, h_t = 1'b0, h_z = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_cnt = 0;
      h_s = '0; h_t = 1'b0; h_z = 1'b0;
    end else if (!m_busy) begin
      if (bus.basla) begin
        m_busy = 1'b1;
        m_cnt  = 1;
        m_lat  = (bus.bolen == 32'd0) ? 1 : LAT;
        model(bus.bolunen, bus.bolen, e_s, e_t, e_z);
      end
    end else begin
      m_cnt++;
      if (m_cnt > m_lat) m_busy = 1'b0;
    end
  end

  // Compare process: every cycle, away from the rising edge
  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_gec;
      exp_gec = m_busy && (m_cnt == m_lat);
      chk(bus.hazir == !m_busy, "hazir", 64'(bus.hazir), 64'(!m_busy));
      chk(bus.gecerli == exp_gec, "gecerli", 64'(bus.gecerli), 64'(exp_gec));
      if (exp_gec) begin
        chk(bus.sonuc == e_s, "sonuc", 64'(bus.sonuc), 64'(e_s));
        chk(bus.tasma == e_t, "tasma", 64'(bus.tasma), 64'(e_t));
        chk(bus.sifira_bolme == e_z, "sifira_bolme", 64'(bus.sifira_bolme), 64'(e_z));
        h_s = e_s; h_t = e_t; h_z = e_z;
      end else if (!m_busy) begin
        chk(bus.sonuc == h_s, "sonuc_held", 64'(bus.sonuc), 64'(h_s));
        chk(bus.tasma == h_t, "tasma_held", 64'(bus.tasma), 64'(h_t));
        chk(bus.sifira_bolme == h_z, "sifira_held", 64'(bus.sifira_bolme), 64'(h_z));
      end else begin
        chk(!bus.tasma && !bus.sifira_bolme, "flags_clear_busy",
            64'({bus.tasma, bus.sifira_bolme}), 64'd0);
      end
    end
  end

  task automatic wait_hazir();
    int w = 0;
    while (!bus.hazir && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk(bus.hazir == 1'b1, "hazir_timeout", 64'(bus.hazir), 64'd1);
  endtask

  // One division with hand-computed expectations; operands scrambled after acceptance
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] es, input bit et, input bit ez,
                         input int elat, input string nm);
    int lat;
    wait_hazir();
    bus.bolunen = a;
    bus.bolen   = b;
    bus.basla   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.basla   = 1'b0;
    bus.bolunen = $urandom;
    bus.bolen   = $urandom;
    lat = 1;
    while (!bus.gecerli && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk(lat == elat, {nm, "_latency"}, 64'(lat), 64'(elat));
    chk(bus.sonuc == es, {nm, "_sonuc"}, 64'(bus.sonuc), 64'(es));
    chk(bus.tasma == et, {nm, "_tasma"}, 64'(bus.tasma), 64'(et));
    chk(bus.sifira_bolme == ez, {nm, "_sifira"}, 64'(bus.sifira_bolme), 64'(ez));
  endtask

  initial begin
    logic [31:0] ms;
    bit mt, mz;
    int cnt;

    bus.basla = 1'b0; bus.bolunen = '0; bus.bolen = '0;

    // Pin the model with literal expectations
    model(32'h0003_0000, 32'h0002_0000, ms, mt, mz);
    chk(ms == 32'h0001_8000 && !mt && !mz, "model_3div2", 64'(ms), 64'h18000);
    model(32'h0001_0000, 32'h0003_0000, ms, mt, mz);
    chk(ms == 32'h0000_5555 && !mt && !mz, "model_1div3", 64'(ms), 64'h5555);
    model(32'h0005_0000, 32'h0000_0000, ms, mt, mz);
    chk(ms == 32'h0 && !mt && mz, "model_div0", 64'({ms, mt, mz}), 64'h1);
`ifdef BOLME_ISARETLI_EN
    model(32'hFFFD_0000, 32'h0002_0000, ms, mt, mz);
    chk(ms == 32'hFFFE_8000 && !mt, "model_neg", 64'(ms), 64'hFFFE8000);
`else
    model(32'h7FFF_0000, 32'h0000_0001, ms, mt, mz);
    chk(ms == 32'hFFFF_FFFF && mt, "model_ovf", 64'(ms), 64'hFFFFFFFF);
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk(bus.hazir && !bus.gecerli && !bus.tasma && !bus.sifira_bolme && bus.sonuc == '0,
        "reset_state", 64'({bus.hazir, bus.gecerli, bus.tasma, bus.sifira_bolme}), 64'h8);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_div(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, LAT, "d3div2");
    run_div(32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0, LAT, "d1div3");
    run_div(32'h0005_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1,   "ddiv0");
    @(negedge clk);
    chk(bus.hazir == 1'b1, "div0_hazir_next", 64'(bus.hazir), 64'd1);
    run_div(32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 1'b0, 1'b0, LAT, "dzero");
    run_div(32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_0000, 1'b0, 1'b0, LAT, "dffff");
`ifdef BOLME_ISARETLI_EN
    run_div(32'hFFFD_0000, 32'h0002_0000, 32'hFFFE_8000, 1'b0, 1'b0, LAT, "dneg");
    run_div(32'h0001_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, LAT, "dposovf");
    run_div(32'h0000_8000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, LAT, "dposedge");
    run_div(32'hFFFF_8000, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, LAT, "dnegmin");
    run_div(32'h8000_0000, 32'h0000_8000, 32'h8000_0000, 1'b1, 1'b0, LAT, "dnegovf");
`else
    run_div(32'h7FFF_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, LAT, "dovf");
    run_div(32'h0001_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, LAT, "dovfedge");
    run_div(32'h0000_8000, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, LAT, "dmaxfit");
`endif

    // basla held high: ignored in the publish cycle, accepted one cycle later
    wait_hazir();
    bus.bolunen = 32'h0003_0000;
    bus.bolen   = 32'h0002_0000;
    bus.basla   = 1'b1;
    cnt = 0;
    while (!bus.gecerli && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.gecerli && cnt < 200);
    bus.basla = 1'b0;
    chk(cnt == LAT + 1, "throughput", 64'(cnt), 64'(LAT + 1));

    // Reset in the middle of an iteration
    wait_hazir();
    bus.bolunen = 32'h0003_0000;
    bus.bolen   = 32'h0002_0000;
    bus.basla   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.basla = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk(bus.hazir && !bus.gecerli && !bus.tasma && !bus.sifira_bolme,
        "midreset_flags", 64'({bus.hazir, bus.gecerli, bus.tasma, bus.sifira_bolme}), 64'h8);
    chk(bus.sonuc == 32'd0, "midreset_sonuc", 64'(bus.sonuc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_div(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, LAT, "after_rst");

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
